// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and instruction memory.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs req/ack fetches and buffers one
// instruction for IF/ID, flushing IF/ID whenever no valid instruction is present.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    if_fetch_unit_if.master         imem,
    input  logic                    id_write_enable_i,
    input  logic                    redirect_i,
    input  logic [31:0]             redirect_pc_i,
    output logic [31:0]             if_instruction_o,
    output logic [31:0]             if_pc_p4_o,
    output logic                    if_flush_o
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_p4_q, buf_pc_p4_d;

    logic [31:0] redirect_target;
    logic [31:0] req_addr_p4;

    assign redirect_target = redirect_pc_i & PC_ALIGN_MASK;
    assign req_addr_p4     = req_addr_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC_ALIGNED;
            req_addr_q  <= RESET_PC_ALIGNED;
            buf_instr_q <= 32'h0;
            buf_pc_p4_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_p4_q <= buf_pc_p4_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_instr_d = buf_instr_q;
        buf_pc_p4_d = buf_pc_p4_q;

        unique case (state_q)
            FETCH: begin
                if (redirect_i) begin
                    pc_d = redirect_target;
                    if (imem.imem_ack) begin
                        req_addr_d = redirect_target;
                    end else begin
                        // Request already on the bus must complete at its old address.
                        state_d = DISCARD;
                    end
                end else if (imem.imem_ack) begin
                    buf_instr_d = imem.imem_rdata;
                    buf_pc_p4_d = req_addr_p4;
                    pc_d        = req_addr_p4;
                    state_d     = HOLD;
                end
            end
            DISCARD: begin
                if (redirect_i) begin
                    pc_d = redirect_target;
                end
                if (imem.imem_ack) begin
                    req_addr_d = redirect_i ? redirect_target : pc_q;
                    state_d    = FETCH;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_d       = redirect_target;
                    req_addr_d = redirect_target;
                    state_d    = FETCH;
                end else if (id_write_enable_i) begin
                    req_addr_d = pc_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Reset gating keeps the bus idle and IF/ID flushed throughout the reset cycle.
    assign imem.imem_req  = ~reset & (state_q != HOLD);
    assign imem.imem_addr = req_addr_q;

    assign if_flush_o       = reset | (state_q != HOLD) | redirect_i;
    assign if_instruction_o = (~reset && state_q == HOLD) ? buf_instr_q : 32'h0;
    assign if_pc_p4_o       = buf_pc_p4_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a configurable-latency memory model.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        id_write_enable;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_p4;
    logic        if_flush;

    int checks;
    int errors;
    int mem_delay;
    int wait_cnt;

    if_fetch_unit_if imem_bus();

    if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk               (clk),
        .reset             (reset),
        .imem              (imem_bus),
        .id_write_enable_i (id_write_enable),
        .redirect_i        (redirect),
        .redirect_pc_i     (redirect_pc),
        .if_instruction_o  (if_instruction),
        .if_pc_p4_o        (if_pc_p4),
        .if_flush_o        (if_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks after mem_delay request cycles, data = addr ^ A5A5_0000.
    assign imem_bus.imem_ack   = imem_bus.imem_req && (wait_cnt >= mem_delay);
    assign imem_bus.imem_rdata = imem_bus.imem_addr ^ 32'hA5A5_0000;

    always @(posedge clk) begin
        if (reset) wait_cnt <= 0;
        else if (imem_bus.imem_req && imem_bus.imem_ack) wait_cnt <= 0;
        else if (imem_bus.imem_req) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(posedge clk) begin
        if (imem_bus.imem_req && imem_bus.imem_ack)
            $display("imem transfer addr=%h rdata=%h", imem_bus.imem_addr, imem_bus.imem_rdata);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        id_write_enable = 1'b1;
        mem_delay = 0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        id_write_enable = 1'b1;
        mem_delay = 0;
        next_cycle();
        next_cycle();
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_bus.imem_req); end
        checks++; if (if_flush !== 1'b1) begin errors++; $display("FAIL reset_flush got %b exp 1", if_flush); end
        checks++; if (if_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", if_instruction); end
        checks++; if (if_pc_p4 !== 32'h0) begin errors++; $display("FAIL reset_pc_p4 got %h exp 0", if_pc_p4); end
        reset = 1'b0;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_bus.imem_req); end
        checks++; if (imem_bus.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL first_addr got %h exp 00000100", imem_bus.imem_addr); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        checks++; if (if_flush !== 1'b1) begin errors++; $display("FAIL zw_c0_flush got %b exp 1", if_flush); end
        next_cycle();
        checks++; if (if_flush !== 1'b0) begin errors++; $display("FAIL zw_c1_flush got %b exp 0", if_flush); end
        checks++; if (if_instruction !== 32'hA5A5_0100) begin errors++; $display("FAIL zw_c1_instr got %h exp a5a50100", if_instruction); end
        checks++; if (if_pc_p4 !== 32'h0000_0104) begin errors++; $display("FAIL zw_c1_pc_p4 got %h exp 00000104", if_pc_p4); end
        checks++; if (imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL zw_c1_req got %b exp 0", imem_bus.imem_req); end
        next_cycle();
        checks++; if (imem_bus.imem_addr !== 32'h0000_0104) begin errors++; $display("FAIL zw_c2_addr got %h exp 00000104", imem_bus.imem_addr); end
        checks++; if (if_flush !== 1'b1) begin errors++; $display("FAIL zw_c2_flush got %b exp 1", if_flush); end
        checks++; if (if_instruction !== 32'h0) begin errors++; $display("FAIL zw_c2_instr got %h exp 0", if_instruction); end
        next_cycle();
        checks++; if (if_instruction !== 32'hA5A5_0104) begin errors++; $display("FAIL zw_c3_instr got %h exp a5a50104", if_instruction); end
        checks++; if (if_pc_p4 !== 32'h0000_0108) begin errors++; $display("FAIL zw_c3_pc_p4 got %h exp 00000108", if_pc_p4); end
        next_cycle();
        checks++; if (imem_bus.imem_addr !== 32'h0000_0108) begin errors++; $display("FAIL zw_c4_addr got %h exp 00000108", imem_bus.imem_addr); end
    endtask

    task automatic test_wait_states();
        do_reset();
        mem_delay = 3;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_bus.imem_addr !== 32'h0000_0100 || if_flush !== 1'b1 || imem_bus.imem_ack !== 1'b0) begin errors++; $display("FAIL ws_wait%0d got addr=%h flush=%b ack=%b exp addr=00000100 flush=1 ack=0", i, imem_bus.imem_addr, if_flush, imem_bus.imem_ack); end
            next_cycle();
        end
        checks++; if (imem_bus.imem_addr !== 32'h0000_0100 || if_flush !== 1'b1 || imem_bus.imem_ack !== 1'b1) begin errors++; $display("FAIL ws_ack got addr=%h flush=%b ack=%b exp addr=00000100 flush=1 ack=1", imem_bus.imem_addr, if_flush, imem_bus.imem_ack); end
        next_cycle();
        checks++; if (if_flush !== 1'b0 || if_instruction !== 32'hA5A5_0100) begin errors++; $display("FAIL ws_deliver got flush=%b instr=%h exp flush=0 instr=a5a50100", if_flush, if_instruction); end
    endtask

    task automatic test_stall();
        do_reset();
        id_write_enable = 1'b0;
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            checks++; if (if_instruction !== 32'hA5A5_0100 || if_pc_p4 !== 32'h0000_0104 || imem_bus.imem_req !== 1'b0 || if_flush !== 1'b0) begin errors++; $display("FAIL stall%0d got instr=%h pc_p4=%h req=%b flush=%b exp a5a50100 00000104 0 0", i, if_instruction, if_pc_p4, imem_bus.imem_req, if_flush); end
            next_cycle();
        end
        id_write_enable = 1'b1;
        #1;
        checks++; if (if_instruction !== 32'hA5A5_0100 || imem_bus.imem_req !== 1'b0) begin errors++; $display("FAIL stall_release got instr=%h req=%b exp a5a50100 0", if_instruction, imem_bus.imem_req); end
        next_cycle();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0000_0104) begin errors++; $display("FAIL stall_next_fetch got req=%b addr=%h exp 1 00000104", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_redirect_hold();
        do_reset();
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        checks++; if (if_flush !== 1'b1) begin errors++; $display("FAIL rh_flush got %b exp 1", if_flush); end
        next_cycle();
        redirect = 1'b0;
        #1;
        checks++; if (imem_bus.imem_addr !== 32'h0000_0200 || if_flush !== 1'b1) begin errors++; $display("FAIL rh_fetch got addr=%h flush=%b exp 00000200 1", imem_bus.imem_addr, if_flush); end
        next_cycle();
        checks++; if (if_instruction !== 32'hA5A5_0200 || if_pc_p4 !== 32'h0000_0204) begin errors++; $display("FAIL rh_deliver got instr=%h pc_p4=%h exp a5a50200 00000204", if_instruction, if_pc_p4); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0400;
        next_cycle();
        redirect = 1'b0;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0000_0400 || if_flush !== 1'b1) begin errors++; $display("FAIL ra_fetch got req=%b addr=%h flush=%b exp 1 00000400 1", imem_bus.imem_req, imem_bus.imem_addr, if_flush); end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        next_cycle();
        next_cycle();
        next_cycle();
        mem_delay = 3;
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0300;
        #1;
        checks++; if (imem_bus.imem_addr !== 32'h0000_0108 || imem_bus.imem_ack !== 1'b0 || if_flush !== 1'b1) begin errors++; $display("FAIL rp_issue got addr=%h ack=%b flush=%b exp 00000108 0 1", imem_bus.imem_addr, imem_bus.imem_ack, if_flush); end
        next_cycle();
        redirect = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0000_0108 || if_flush !== 1'b1) begin errors++; $display("FAIL rp_discard%0d got req=%b addr=%h flush=%b exp 1 00000108 1", i, imem_bus.imem_req, imem_bus.imem_addr, if_flush); end
            next_cycle();
        end
        checks++; if (imem_bus.imem_addr !== 32'h0000_0300 || if_flush !== 1'b1 || if_instruction !== 32'h0) begin errors++; $display("FAIL rp_refetch got addr=%h flush=%b instr=%h exp 00000300 1 0", imem_bus.imem_addr, if_flush, if_instruction); end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        next_cycle();
        redirect = 1'b0;
        #1;
        checks++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_bus.imem_addr); end
        next_cycle();
        checks++; if (if_instruction !== 32'h5A5A_FFFC || if_pc_p4 !== 32'h0 || if_flush !== 1'b0) begin errors++; $display("FAIL wrap_deliver got instr=%h pc_p4=%h flush=%b exp 5a5afffc 00000000 0", if_instruction, if_pc_p4, if_flush); end
        next_cycle();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got req=%b addr=%h exp 1 00000000", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        next_cycle();
        mem_delay = 5;
        next_cycle();
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_ack !== 1'b0) begin errors++; $display("FAIL rm_pending got req=%b ack=%b exp 1 0", imem_bus.imem_req, imem_bus.imem_ack); end
        reset = 1'b1;
        next_cycle();
        checks++; if (imem_bus.imem_req !== 1'b0 || if_flush !== 1'b1 || if_instruction !== 32'h0 || if_pc_p4 !== 32'h0) begin errors++; $display("FAIL rm_reset got req=%b flush=%b instr=%h pc_p4=%h exp 0 1 0 0", imem_bus.imem_req, if_flush, if_instruction, if_pc_p4); end
        reset = 1'b0;
        #1;
        checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL rm_restart got req=%b addr=%h exp 1 00000100", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mem_delay = 0;
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        id_write_enable = 1'b1;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_redirect_hold();
        test_redirect_ack();
        test_redirect_pending();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage that feeds the IF/ID pipeline register. Owns the program counter and runs a req/ack transaction to instruction memory. Buffers one fetched instruction until decode accepts it, and generates the Flush (bubble) control that the IF/ID register consumes when no valid instruction is available or a control-flow redirect kills the wrong-path instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address, stable while imem_req=1 and no ack
- imem_ack  in  1  transfer completes on an edge with imem_req=1 and imem_ack=1 (same-cycle ack allowed)
- imem_rdata  in  32  instruction word, valid only in the ack cycle
- id_write_enable  in  1  IF/ID write enable from the hazard unit (0 = decode stalled)
- redirect  in  1  taken branch/jump from a later stage
- redirect_pc  in  32  target PC; bits [1:0] ignored and forced to 0
- if_instruction  out  32  instruction to IF/ID
- if_pc_p4  out  32  PC+4 of if_instruction to IF/ID
- if_flush  out  1  Flush to IF/ID (1 = IF/ID captures NOP)

## Operation
- Registers: pc (next fetch PC), req_addr (address of the outstanding request), buf_instr, buf_pc_p4, state.
- States: FETCH, HOLD, DISCARD.
- FETCH: imem_req=1, imem_addr=req_addr.
  - ack with no redirect: buf_instr<=imem_rdata, buf_pc_p4<=req_addr+4, pc<=req_addr+4, go to HOLD.
  - redirect with ack in the same cycle: drop data, pc<=req_addr<=redirect_pc, stay in FETCH.
  - redirect with no ack: pc<=redirect_pc, go to DISCARD. req_addr is unchanged.
  - no ack, no redirect: hold.
- DISCARD: imem_req=1, imem_addr=req_addr (the old address, kept stable).
  - ack: drop data, req_addr<=pc, go to FETCH.
  - further redirects overwrite pc; the state is unchanged.
  - redirect with ack in the same cycle: req_addr<=redirect_pc, go to FETCH.
- HOLD: imem_req=0. Buffer is valid.
  - redirect: drop buffer, pc<=req_addr<=redirect_pc, go to FETCH. Redirect has priority over consumption.
  - else, id_write_enable=1: instruction consumed, req_addr<=pc, go to FETCH.
  - else: stay; buffer held indefinitely while stalled.
- Output logic (combinational):
  - if_flush = (state!=HOLD) | redirect.
  - if_instruction = buf_instr when state==HOLD, else 32'h0.
  - if_pc_p4 = buf_pc_p4 always.
- Arithmetic: all PC math is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - state=FETCH, pc=req_addr=RESET_PC.
  - buf_instr=0, buf_pc_p4=0.
  - imem_req=0 during the reset cycle.
  - if_flush=1, if_instruction=0, if_pc_p4=0.
- First request (imem_req=1, imem_addr=RESET_PC) starts in the cycle after reset deasserts.
- Latency: ack at edge N → instruction presented (if_flush=0) in cycle N+1 → captured by IF/ID at edge N+1 if id_write_enable=1.
- Peak throughput: one instruction per 2 cycles (FETCH+HOLD) with a zero-wait memory.
- While id_write_enable=0 in HOLD, outputs are stable and no new request is issued.
- Reset mid-transaction: the outstanding request is abandoned. Memory shares the reset and must drop it. No data is delivered.
- Redirect is sampled every cycle. Its effect on if_flush is same-cycle; its effect on the PC is at the next edge.

## Test plan
- Reset with RESET_PC=32'h0000_0100, zero-wait memory returning addr^32'hA5A5_0000, id_write_enable=1 → imem_addr sequence 0x100, 0x104, 0x108 on alternating cycles; IF/ID sees 0xA5A5_0100 (pc_p4 0x104), then 0xA5A5_0104 (pc_p4 0x108); if_flush=1 between them.
- Memory ack delayed 3 cycles → imem_addr held constant and if_flush=1 for all wait cycles; instruction appears the cycle after ack.
- In HOLD, drive id_write_enable=0 for 4 cycles → if_instruction and if_pc_p4 constant, imem_req=0. Release → next fetch issued the following cycle.
- Redirect to 0x200 in HOLD while id_write_enable=1 → if_flush=1 in that cycle, the buffered instruction is never delivered, and the next imem_addr is 0x200.
- Redirect to 0x300 while a FETCH at 0x108 is unacked → imem_addr stays 0x108 until ack. Returned word is discarded (if_flush stays 1), then the request goes to 0x300.
- pc=32'hFFFF_FFFC fetched → if_pc_p4=0 and the next imem_addr is 32'h0000_0000. Reset asserted during a pending request → imem_req=0 next cycle and the outputs return to their reset values.
